// File: rtl/hamming_decoder.sv
// Hamming(7,4) serial decoder: corrects one bit error per codeword, emits d1..d4 serially.
// Latency: d1 appears the cycle after the edge that samples position 7; d2..d4 follow back to back.
// No back-pressure: input is taken whenever din_valid=1, and output drains unconditionally in 4 cycles.
module hamming_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  output logic dout,
  output logic dout_valid,
  output logic err_corrected
);

  // Input framing: shift register (position 1 ends up in bit 6) and position counter 0..6
  logic [6:0] in_sr;
  logic [2:0] bit_cnt;

  // Output side: d1 at bit 3, remaining-bit counter, correction marker for the d1 cycle
  logic [3:0] out_sr;
  logic [2:0] out_cnt;
  logic       err_flag;

  // Decode path, evaluated on the position-7 edge
  logic [6:0] word;
  logic [6:0] fixed;
  logic [2:0] syn;
  logic [3:0] data;
  logic       last_bit;

  assign last_bit = din_valid && (bit_cnt == 3'd6);

  // Assemble the full codeword with the incoming bit, compute syndrome and flip the erroneous position.
  // Position k lives at word[7-k], so c1 = word[6] and c7 = word[0].
  always_comb begin
    word   = {in_sr[5:0], din};
    syn[0] = word[6] ^ word[4] ^ word[2] ^ word[0];
    syn[1] = word[5] ^ word[4] ^ word[1] ^ word[0];
    syn[2] = word[3] ^ word[2] ^ word[1] ^ word[0];
    fixed  = word;
    if (syn != 3'd0) begin
      fixed[3'd7 - syn] = ~word[3'd7 - syn];
    end
    // d1 = c3, d2 = c5, d3 = c6, d4 = c7
    data = {fixed[4], fixed[2], fixed[1], fixed[0]};
  end

  // Input shift register and position counter; only valid bits advance the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sr   <= 7'd0;
      bit_cnt <= 3'd0;
    end else if (din_valid) begin
      in_sr   <= {in_sr[5:0], din};
      bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  // Output register: load the corrected nibble on the position-7 edge, otherwise drain one bit per cycle.
  // The drain always finishes before the next load can happen, so load has no conflict with shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr   <= 4'd0;
      out_cnt  <= 3'd0;
      err_flag <= 1'b0;
    end else if (last_bit) begin
      out_sr   <= data;
      out_cnt  <= 3'd4;
      err_flag <= (syn != 3'd0);
    end else begin
      err_flag <= 1'b0;
      if (out_cnt != 3'd0) begin
        out_sr  <= {out_sr[2:0], 1'b0};
        out_cnt <= out_cnt - 3'd1;
      end
    end
  end

  // Drive outputs from the output register; dout is forced low when idle
  always_comb begin
    dout_valid    = (out_cnt != 3'd0);
    dout          = dout_valid & out_sr[3];
    err_corrected = err_flag;
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed-vector bench for hamming_decoder: hand-computed nibbles, flags and output timing.
module tb_hamming_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic din;
  logic din_valid;
  logic dout;
  logic dout_valid;
  logic err_corrected;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stray_err = 0;

  typedef struct {
    logic d;
    logic e;
    int   c;
  } rec_t;

  rec_t       obs[$];
  int         t7q[$];
  logic [3:0] exp_d[$];
  logic       exp_e[$];

  hamming_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (din),
    .din_valid     (din_valid),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .err_corrected (err_corrected)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output bit on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (dout_valid) begin
      rec_t r;
      r.d = dout;
      r.e = err_corrected;
      r.c = cyc;
      obs.push_back(r);
    end else if (err_corrected) begin
      stray_err = stray_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din       = 1'b0;
    repeat (n) tick();
  endtask

  // Send one codeword (bit 6 = position 1) with optional gaps after positions 2 and 5
  task automatic send_word(input logic [6:0] w, input int gap2, input int gap5,
                           input logic [3:0] d, input logic e);
    for (int k = 0; k < 7; k++) begin
      din       = w[6-k];
      din_valid = 1'b1;
      tick();
      if (k == 6) begin
        t7q.push_back(cyc);
        exp_d.push_back(d);
        exp_e.push_back(e);
      end
      if (k == 1 && gap2 > 0) begin
        din_valid = 1'b0;
        repeat (gap2) tick();
      end
      if (k == 4 && gap5 > 0) begin
        din_valid = 1'b0;
        repeat (gap5) tick();
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic clear_log();
    obs.delete();
    t7q.delete();
    exp_d.delete();
    exp_e.delete();
    stray_err = 0;
  endtask

  // Compare recorded output against the expected bursts, one burst per codeword sent
  task automatic verify(input string name);
    chk($sformatf("%s count", name), obs.size(), 4 * exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        int idx = 4 * i + j;
        if (idx < obs.size()) begin
          chk($sformatf("%s w%0d d%0d", name, i, j + 1), obs[idx].d, exp_d[i][3-j]);
          chk($sformatf("%s w%0d err%0d", name, i, j + 1), obs[idx].e, (j == 0) ? exp_e[i] : 1'b0);
          chk($sformatf("%s w%0d cyc%0d", name, i, j + 1), obs[idx].c, t7q[i] + j);
        end
      end
    end
    chk($sformatf("%s stray err", name), stray_err, 0);
    clear_log();
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    repeat (2) tick();
    chk("reset dout", dout, 1'b0);
    chk("reset dout_valid", dout_valid, 1'b0);
    chk("reset err", err_corrected, 1'b0);
    rst_n = 1'b1;
    idle(2);
    clear_log();

    // Clean word, data 1011
    send_word(7'b0110011, 0, 0, 4'b1011, 1'b0);
    idle(8);
    verify("clean");

    // c5 flipped, syndrome 5
    send_word(7'b0110111, 0, 0, 4'b1011, 1'b1);
    idle(8);
    verify("data_err");

    // p1 flipped, syndrome 1
    send_word(7'b1110011, 0, 0, 4'b1011, 1'b1);
    idle(8);
    verify("parity_err");

    // c7 (d4) flipped, syndrome 7
    send_word(7'b0110010, 0, 0, 4'b1011, 1'b1);
    idle(8);
    verify("d4_err");

    // c6 and c7 flipped: syndrome 1, p1 miscorrected, data stays 1000, flag still pulses
    send_word(7'b0110000, 0, 0, 4'b1000, 1'b1);
    idle(8);
    verify("double_err");

    // Gaps of 3 idle cycles after bits 2 and 5
    send_word(7'b0110011, 3, 3, 4'b1011, 1'b0);
    idle(8);
    verify("gapped");

    // Back-to-back stream, continuous valid
    send_word(7'b0000000, 0, 0, 4'b0000, 1'b0);
    send_word(7'b1111111, 0, 0, 4'b1111, 1'b0);
    send_word(7'b0110011, 0, 0, 4'b1011, 1'b0);
    idle(8);
    chk("b2b spacing 1", t7q[1] - t7q[0], 7);
    chk("b2b spacing 2", t7q[2] - t7q[1], 7);
    verify("b2b");

    // Reset after 4 bits of a word: partial input discarded
    for (int k = 0; k < 4; k++) begin
      din       = k[0];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    chk("midword rst dout", dout, 1'b0);
    chk("midword rst dout_valid", dout_valid, 1'b0);
    chk("midword rst err", err_corrected, 1'b0);
    tick();
    rst_n = 1'b1;
    idle(1);
    chk("midword rst no output", obs.size(), 0);
    send_word(7'b0110011, 0, 0, 4'b1011, 1'b0);
    idle(8);
    verify("reset_midword");

    // Reset while output is draining: aborts immediately
    send_word(7'b0110011, 0, 0, 4'b1011, 1'b0);
    tick();
    chk("drain pre-rst valid", dout_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("drain rst dout_valid", dout_valid, 1'b0);
    chk("drain rst dout", dout, 1'b0);
    clear_log();
    tick();
    rst_n = 1'b1;
    idle(6);
    chk("drain rst no output", obs.size(), 0);
    send_word(7'b1111111, 0, 0, 4'b1111, 1'b0);
    idle(8);
    verify("after_drain_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
